serial_add_unit: RTL and testbench

- Bit-serial WIDTH-bit binary adder: the addition counterpart of the team's ripple-borrow parallel subtractor.
- Reuses one full-adder cell over WIDTH clock cycles, LSB first, with a registered carry.
- Operands enter and results leave through valid/ready handshakes, so the block can sit between the operand source and the result consumer in the arithmetic lab datapath.

---
 rtl/add_pkg.sv | 12 +
 rtl/fa1bit.sv | 13 +
 rtl/serial_add_unit.sv | 115 +++++++++++
 tb/tb_serial_add_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared types and limits for the bit-serial adder.
package add_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa1bit.sv
// Single-bit full-adder cell, reused once per cycle by the serial datapath.
module fa1bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial WIDTH-bit adder: one full-adder cell over WIDTH cycles, LSB first,
// with valid/ready handshakes on operands and result.
module serial_add_unit
    import add_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    if (WIDTH == 0 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("serial_add_unit: WIDTH out of range");
    end

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   sum_sr;
    logic [WIDTH-1:0]   sum_next;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               sum_bit;
    logic               carry_next;
    logic               accept;
    logic               last;

    assign accept = in_valid & in_ready;
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    // Sum register with the new bit entering at the MSB.
    assign sum_next = WIDTH'({sum_bit, sum_sr} >> 1);

    fa1bit u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (sum_bit),
        .co (carry_next)
    );

    // State register; handshake flags are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Serial datapath: operand shift, carry, sum collection and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            s      <= '0;
            co     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        carry  <= ci;
                        sum_sr <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= carry_next;
                    sum_sr <= sum_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        s  <= sum_next;
                        co <= carry_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_unit.sv
// Self-checking bench for serial_add_unit against an arithmetic reference model.
module tb_serial_add_unit;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         co;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_add_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // {co, s} of the exact integer sum.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        ci       = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 64) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({in_ready, out_valid, s, co} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got in_ready=%b out_valid=%b s=%0d co=%b, expected all 0",
                     in_ready, out_valid, s, co);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready_early: got %b expected 0", in_ready);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic;
        int cyc;
        logic [W:0] exp;
        out_ready = 1'b1;
        exp = ref_add(4'd5, 4'd3, 1'b0);
        accept_op(4'd5, 4'd3, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_run_flags: got in_ready=%b out_valid=%b expected 0 0",
                     in_ready, out_valid);
        end
        wait_valid(cyc);
        n_checks++;
        if (cyc != W) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected %0d", cyc, W);
        end
        n_checks++;
        if ({co, s} !== exp) begin
            n_fail++;
            $display("FAIL basic_sum: got co=%b s=%0d expected co=%b s=%0d", co, s, exp[W], exp[W-1:0]);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_after_handshake: got out_valid=%b in_ready=%b expected 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_corner_values;
        logic [W-1:0] xs [4] = '{4'd15, 4'd15, 4'd0, 4'd0};
        logic [W-1:0] ys [4] = '{4'd1,  4'd15, 4'd0, 4'd15};
        logic         cs [4] = '{1'b0,  1'b1,  1'b1, 1'b1};
        int cyc;
        logic [W:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = ref_add(xs[i], ys[i], cs[i]);
            accept_op(xs[i], ys[i], cs[i]);
            wait_valid(cyc);
            n_checks++;
            if (out_valid !== 1'b1 || {co, s} !== exp) begin
                n_fail++;
                $display("FAIL corner_%0d: got valid=%b co=%b s=%0d expected valid=1 co=%b s=%0d",
                         i, out_valid, co, s, exp[W], exp[W-1:0]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        logic [W:0] exp;
        out_ready = 1'b0;
        exp = ref_add(4'd9, 4'd4, 1'b0);
        accept_op(4'd9, 4'd4, 1'b0);
        wait_valid(cyc);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {co, s} !== exp) begin
                n_fail++;
                $display("FAIL backpressure_hold_%0d: got valid=%b ready=%b co=%b s=%0d expected 1 0 %b %0d",
                         i, out_valid, in_ready, co, s, exp[W], exp[W-1:0]);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_single_result: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_ignored_input;
        int cyc;
        bit extra;
        logic [W:0] exp;
        out_ready = 1'b0;
        exp = ref_add(4'd2, 4'd1, 1'b0);
        accept_op(4'd2, 4'd1, 1'b0);
        in_valid = 1'b1; a = 4'd7; b = 4'd7; ci = 1'b1;
        tick();
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
        wait_valid(cyc);
        n_checks++;
        if (out_valid !== 1'b1 || {co, s} !== exp) begin
            n_fail++;
            $display("FAIL ignored_sum: got valid=%b co=%b s=%0d expected valid=1 co=%b s=%0d",
                     out_valid, co, s, exp[W], exp[W-1:0]);
        end
        out_ready = 1'b1;
        tick();
        extra = 1'b0;
        for (int i = 0; i < int'(W) + 3; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) extra = 1'b1;
            tick();
        end
        n_checks++;
        if (extra) begin
            n_fail++;
            $display("FAIL ignored_no_second_result: got extra activity=1 expected 0");
        end
    endtask

    task automatic test_async_reset;
        int cyc;
        logic [W:0] exp;
        out_ready = 1'b1;
        accept_op(4'd6, 4'd6, 1'b0);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, s, co, in_ready} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got valid=%b s=%0d co=%b ready=%b expected all 0",
                     out_valid, s, co, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_recover: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
        end
        exp = ref_add(4'd1, 4'd2, 1'b0);
        accept_op(4'd1, 4'd2, 1'b0);
        wait_valid(cyc);
        n_checks++;
        if (out_valid !== 1'b1 || cyc != W || {co, s} !== exp) begin
            n_fail++;
            $display("FAIL async_reset_next_op: got valid=%b cycles=%0d co=%b s=%0d expected 1 %0d %b %0d",
                     out_valid, cyc, co, s, W, exp[W], exp[W-1:0]);
        end
        tick();
    endtask

    task automatic test_random;
        int cyc;
        int d;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic c;
        logic [W:0] exp;
        for (int n = 0; n < 20; n++) begin
            x = W'($urandom); y = W'($urandom); c = 1'($urandom);
            exp = ref_add(x, y, c);
            d = int'($urandom_range(0, 3));
            out_ready = 1'b0;
            accept_op(x, y, c);
            wait_valid(cyc);
            n_checks++;
            if (out_valid !== 1'b1 || cyc != W || {co, s} !== exp) begin
                n_fail++;
                $display("FAIL random_%0d: %0d+%0d+%0d got valid=%b cycles=%0d co=%b s=%0d expected co=%b s=%0d",
                         n, x, y, c, out_valid, cyc, co, s, exp[W], exp[W-1:0]);
            end
            for (int i = 0; i < d; i++) begin
                tick();
                n_checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || {co, s} !== exp) begin
                    n_fail++;
                    $display("FAIL random_stall_%0d: got valid=%b ready=%b co=%b s=%0d", n, out_valid,
                             in_ready, co, s);
                end
            end
            out_ready = 1'b1;
            tick();
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL random_handshake_%0d: got valid=%b ready=%b expected 0 1", n, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [W:0] q[$];
        logic [W:0] exp;
        int last_acc;
        int n_acc;
        int n_res;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
        last_acc = -1;
        n_acc = 0;
        n_res = 0;
        for (int cyc = 0; cyc < 60 + 2 * int'(W); cyc++) begin
            if (out_valid === 1'b1) begin
                exp = (q.size() > 0) ? q.pop_front() : '1;
                n_res++;
                n_checks++;
                if ({co, s} !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_result_%0d: got co=%b s=%0d expected co=%b s=%0d",
                             n_res, co, s, exp[W], exp[W-1:0]);
                end
            end
            if (in_ready === 1'b1 && in_valid === 1'b1) begin
                q.push_back(ref_add(a, b, ci));
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc != int'(W) + 2) begin
                        n_fail++;
                        $display("FAIL b2b_interval: got %0d expected %0d", cyc - last_acc, W + 2);
                    end
                end
                last_acc = cyc;
                n_acc++;
            end
            tick();
            a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
            if (cyc == 59) in_valid = 1'b0;
        end
        n_checks++;
        if (q.size() != 0 || n_acc < 5 || n_res != n_acc) begin
            n_fail++;
            $display("FAIL b2b_drain: got pending=%0d accepted=%0d results=%0d expected 0 >=5 equal",
                     q.size(), n_acc, n_res);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corner_values();
        test_backpressure();
        test_ignored_input();
        test_async_reset();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
